misr_bist_ctrl: RTL and testbench

//  Sequencer that runs one complete MISR compaction test without software polling.
//  Per run it: latches coefficients, golden signature and beat count; pulses the

---
 rtl/misr_bist_ctrl_pkg.sv | 6 +
 rtl/misr_bist_ctrl_if.sv | 32 +++
 rtl/misr_bist_ctrl.sv | 87 ++++++++
 tb/tb_misr_bist_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/misr_bist_ctrl_pkg.sv
// misr_ctrl_pkg: state encoding and default widths for the MISR BIST sequencer
package misr_ctrl_pkg;
  localparam int NBIT_DATA_DEF = 64;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, CHECK, DONE} misr_ctrl_state_t;
endpackage

// File: rtl/misr_bist_ctrl_if.sv
// misr_bist_ctrl_if: control/status and MISR datapath signals of the BIST sequencer
//  master: register block + MISR side (drives requests, data beat, signature)
//  slave : sequencer side (drives MISR enable/reset/coefficients and status)
interface misr_bist_ctrl_if
  import misr_ctrl_pkg::*;
#(
  parameter int NBIT_DATA = NBIT_DATA_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic start_i;
  logic abort_i;
  logic [CNT_W-1:0] cycles_i;
  logic [NBIT_DATA-1:0] coeff_i;
  logic [NBIT_DATA-1:0] golden_i;
  logic valid_i;
  logic [NBIT_DATA-1:0] signature_i;
  logic misr_en_o;
  logic misr_rst_no;
  logic [NBIT_DATA-1:0] coeff_o;
  logic busy_o;
  logic done_o;
  logic pass_o;
  logic [NBIT_DATA-1:0] sig_o;
  modport master (
    output start_i, abort_i, cycles_i, coeff_i, golden_i, valid_i, signature_i,
    input misr_en_o, misr_rst_no, coeff_o, busy_o, done_o, pass_o, sig_o
  );
  modport slave (
    input start_i, abort_i, cycles_i, coeff_i, golden_i, valid_i, signature_i,
    output misr_en_o, misr_rst_no, coeff_o, busy_o, done_o, pass_o, sig_o
  );
endinterface

// File: rtl/misr_bist_ctrl.sv
// misr_bist_ctrl: runs one MISR compaction test (clear, N beats, settle, compare, report)
//  clk_i  : clock
//  rst_ni : asynchronous active-low reset
//  bus    : slave side of misr_bist_ctrl_if (start/abort/config in, MISR control and status out)
module misr_bist_ctrl
  import misr_ctrl_pkg::*;
#(
  parameter int NBIT_DATA = NBIT_DATA_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk_i,
  input logic rst_ni,
  misr_bist_ctrl_if.slave bus
);
  misr_ctrl_state_t state;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] cnt;
  logic [NBIT_DATA-1:0] golden_q;
  logic [NBIT_DATA-1:0] coeff_q;
  logic [NBIT_DATA-1:0] sig_q;
  logic misr_rst_nq;
  logic busy_q;
  logic done_q;
  logic pass_q;
  // enable follows the beat combinationally so the MISR captures the same cycle's data;
  // abort kills it in the very cycle it is raised
  assign bus.misr_en_o = state == RUN && bus.valid_i && !bus.abort_i;
  assign bus.misr_rst_no = misr_rst_nq;
  assign bus.coeff_o = coeff_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.pass_o = pass_q;
  assign bus.sig_o = sig_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      n_q <= '0;
      cnt <= '0;
      golden_q <= '0;
      coeff_q <= '0;
      sig_q <= '0;
      misr_rst_nq <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      misr_rst_nq <= 1'b1;
      if (state != IDLE && bus.abort_i) begin
        state <= IDLE;
        busy_q <= 1'b0;
        pass_q <= 1'b0;
      end else
        case (state)
          IDLE:
            if (bus.start_i && !bus.abort_i) begin
              n_q <= bus.cycles_i;
              coeff_q <= bus.coeff_i;
              golden_q <= bus.golden_i;
              misr_rst_nq <= 1'b0;
              busy_q <= 1'b1;
              state <= CLEAR;
            end
          CLEAR: begin
            cnt <= n_q;
            state <= n_q != '0 ? RUN : SETTLE;
          end
          RUN:
            if (bus.valid_i) begin
              cnt <= cnt - 1'b1;
              state <= cnt == CNT_W'(1) ? SETTLE : RUN;
            end
          SETTLE: state <= CHECK;
          CHECK: begin
            sig_q <= bus.signature_i;
            pass_q <= bus.signature_i == golden_q;
            state <= DONE;
          end
          DONE: begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_misr_bist_ctrl.sv
// tb_misr_bist_ctrl: directed vectors with a queue scoreboard checked on every done_o pulse
module tb_misr_bist_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int rl_cnt = 0;
  typedef struct {
    logic p;
    logic [63:0] s;
    logic [63:0] c;
    int t;
    int n;
  } exp_t;
  exp_t exp_q[$];
  misr_bist_ctrl_if #(.NBIT_DATA(64), .CNT_W(16)) bus ();
  misr_bist_ctrl #(.NBIT_DATA(64), .CNT_W(16)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  always @(negedge clk_i) begin
    exp_t e;
    if (bus.done_o) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("pass_o", 64'(bus.pass_o), 64'(e.p));
        chk("sig_o", bus.sig_o, e.s);
        chk("coeff_o", bus.coeff_o, e.c);
        chk("done_cycle", 64'(cyc), 64'(e.t));
        chk("en_pulses", 64'(en_cnt), 64'(e.n));
        chk("rst_low_cycles", 64'(rl_cnt), 64'd1);
      end
      en_cnt = 0;
      rl_cnt = 0;
    end else if (!bus.busy_o) begin
      en_cnt = 0;
      rl_cnt = 0;
    end else begin
      en_cnt += int'(bus.misr_en_o);
      rl_cnt += int'(!bus.misr_rst_no);
    end
  end
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic launch(input int n, input logic [63:0] cf, gold, sig);
    bus.cycles_i = 16'(n);
    bus.coeff_i = cf;
    bus.golden_i = gold;
    bus.signature_i = sig;
    bus.valid_i = 1'b0;
    bus.start_i = 1'b1;
  endtask
  task automatic run_vec(input int n, input logic [15:0] pat, input int plen,
                         input logic [63:0] cf, gold, sig, input logic ep, input int lat);
    step();
    exp_q.push_back('{ep, sig, cf, cyc + 1 + lat, n});
    launch(n, cf, gold, sig);
    step();
    bus.start_i = 1'b0;
    bus.valid_i = 1'b1;
    for (int i = 0; i < plen; i++) begin
      step();
      bus.valid_i = pat[i];
    end
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      step();
      bus.valid_i = 1'b1;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_misr_en_o"}, 64'(bus.misr_en_o), 64'd0);
    chk({tag, "_misr_rst_no"}, 64'(bus.misr_rst_no), 64'd0);
    chk({tag, "_coeff_o"}, bus.coeff_o, 64'd0);
    chk({tag, "_busy_o"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_done_o"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_pass_o"}, 64'(bus.pass_o), 64'd0);
    chk({tag, "_sig_o"}, bus.sig_o, 64'd0);
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.cycles_i = '0;
    bus.coeff_i = '0;
    bus.golden_i = '0;
    bus.valid_i = 1'b0;
    bus.signature_i = '0;
    repeat (3) step();
    chk_reset_vals("por");
    rst_ni = 1'b1;
    step();
    chk("idle_misr_rst_no", 64'(bus.misr_rst_no), 64'd1);
    run_vec(4, 16'h0, 0, 64'hC0EF_0004, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 8);
    step();
    bus.abort_i = 1'b1;
    bus.start_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    chk("idle_abort_pass_kept", 64'(bus.pass_o), 64'd1);
    chk("idle_abort_start_blocked", 64'(bus.busy_o), 64'd0);
    run_vec(3, 16'b10101, 5, 64'hC0EF_0003, 64'hA5A5, 64'hA5A5, 1'b1, 9);
    run_vec(2, 16'h0, 0, 64'hC0EF_0002, 64'hDEAD, 64'hBEEF, 1'b0, 6);
    run_vec(0, 16'h0, 0, 64'hC0EF_0000, 64'h77, 64'h77, 1'b1, 4);
    run_vec(1, 16'h0, 0, 64'hC0EF_0001, 64'hFACE, 64'hFACE, 1'b1, 5);
    step();
    launch(10, 64'h5555, 64'h9, 64'h9);
    step();
    bus.start_i = 1'b0;
    bus.valid_i = 1'b1;
    repeat (2) step();
    bus.start_i = 1'b1;
    bus.cycles_i = 16'd2;
    step();
    bus.start_i = 1'b0;
    chk("start_in_run_busy", 64'(bus.busy_o), 64'd1);
    step();
    bus.abort_i = 1'b1;
    @(negedge clk_i);
    chk("abort_en_immediate", 64'(bus.misr_en_o), 64'd0);
    chk("abort_busy_same_cycle", 64'(bus.busy_o), 64'd1);
    step();
    bus.abort_i = 1'b0;
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    chk("abort_pass", 64'(bus.pass_o), 64'd0);
    chk("abort_sig_kept", bus.sig_o, 64'hFACE);
    repeat (15) step();
    chk("no_restart_after_abort", 64'(bus.busy_o), 64'd0);
    launch(10, 64'hAAAA, 64'h3, 64'h3);
    step();
    bus.start_i = 1'b0;
    bus.valid_i = 1'b1;
    repeat (4) step();
    chk("mid_run_en", 64'(bus.misr_en_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    chk("post_reset_busy", 64'(bus.busy_o), 64'd0);
    chk("post_reset_misr_rst_no", 64'(bus.misr_rst_no), 64'd1);
    repeat (12) step();
    chk("post_reset_stays_idle", 64'(bus.busy_o), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
